// File: rtl/adc_sched.sv
// adc_sched: round-robin scheduler for four requesters sharing one ADC macro.
// Define ADC_SCHED_AVG_EN to average four post-discard samples per conversion.
module adc_sched #(
  parameter int SETTLE  = 64,
  parameter int DISCARD = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic        temp_clk,
  input  logic        reset_n,
  input  logic [3:0]  req,
  input  logic [15:0] req_cfg,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic [9:0]  result,
  output logic        err,
  output logic        adc_pwdb,
  output logic        adc_rst,
  output logic        adc_temp,
  output logic [7:0]  adc_ainsel,
  input  logic        adc_eoc,
  input  logic [9:0]  adc_xd
);

  localparam int CW = 16;
  localparam int EW = 8;
`ifdef ADC_SCHED_AVG_EN
  localparam int NSAMP = 4;
`else
  localparam int NSAMP = 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_SETTLE, S_CONV, S_DONE
  } state_t;

  state_t         state, nxt;
  logic [1:0]     ptr, win;
  logic           win_v;
  logic [3:0]     win_cfg, cfg_q, gnt_q;
  logic [CW-1:0]  cnt;
  logic [EW-1:0]  ecnt;
  logic           eoc_q, rise, pwr_q, err_q;
  logic           skip, settle_end, tmo_hit, cap_last;
  logic [9:0]     res_q, cap_val;

  assign rise       = adc_eoc & ~eoc_q;
  assign settle_end = (cnt == CW'(SETTLE - 1));
  assign tmo_hit    = (cnt == CW'(TIMEOUT - 1));
  assign cap_last   = rise && (ecnt == EW'(DISCARD + NSAMP - 1));
  assign win_cfg    = req_cfg[{win, 2'b00} +: 4];
  assign skip       = pwr_q && (win_cfg == cfg_q);

`ifdef ADC_SCHED_AVG_EN
  logic [11:0] acc, sum;
  assign sum     = acc + {2'b00, adc_xd};
  assign cap_val = sum[11:2];

  // accumulate post-discard samples during a conversion
  always_ff @(posedge temp_clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (state != S_CONV) begin
      acc <= '0;
    end else if (rise && ecnt >= EW'(DISCARD)) begin
      acc <= sum;
    end
  end
`else
  assign cap_val = adc_xd;
`endif

  // first requesting index searching round-robin from ptr
  always_comb begin
    win   = '0;
    win_v = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        win   = ptr + 2'(k);
        win_v = 1'b1;
      end
    end
  end

  // state register
  always_ff @(posedge temp_clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (|req) nxt = S_ARB;
      S_ARB:    if (!win_v)   nxt = S_IDLE;
                else if (skip) nxt = S_CONV;
                else           nxt = S_SETTLE;
      S_SETTLE: if (settle_end) nxt = S_CONV;
      S_CONV:   if (cap_last || (!rise && tmo_hit)) nxt = S_DONE;
      S_DONE:   nxt = (|req) ? S_ARB : S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // counters, grant/cfg latch, pointer and result capture
  always_ff @(posedge temp_clk or negedge reset_n) begin
    if (!reset_n) begin
      eoc_q <= 1'b0;
      cnt   <= '0;
      ecnt  <= '0;
      pwr_q <= 1'b0;
      gnt_q <= '0;
      cfg_q <= '0;
      ptr   <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      eoc_q <= adc_eoc;
      pwr_q <= (nxt != S_IDLE) && (pwr_q || nxt == S_SETTLE);
      if (state != nxt || (state == S_CONV && rise))
        cnt <= '0;
      else if (state == S_SETTLE || state == S_CONV)
        cnt <= cnt + CW'(1);
      if (state != S_CONV) ecnt <= '0;
      else if (rise)       ecnt <= ecnt + EW'(1);
      if (state == S_ARB) begin
        if (win_v) begin
          gnt_q <= 4'b0001 << win;
          cfg_q <= win_cfg;
          ptr   <= win + 2'd1;
        end else begin
          gnt_q <= '0;
        end
      end
      if (state == S_DONE && nxt == S_IDLE) gnt_q <= '0;
      if (state == S_CONV && nxt == S_DONE) begin
        res_q <= cap_last ? cap_val : 10'h3FF;
        err_q <= !cap_last;
      end
    end
  end

  // outputs decoded from state and latched registers
  always_comb begin
    grant      = gnt_q;
    done       = (state == S_DONE) ? gnt_q : 4'b0;
    err        = (state == S_DONE) && err_q;
    result     = res_q;
    adc_pwdb   = pwr_q;
    adc_rst    = (state == S_IDLE) ||
                 (state == S_ARB && !pwr_q) ||
                 (state == S_SETTLE && cnt == '0);
    adc_temp   = pwr_q && cfg_q[3];
    adc_ainsel = (pwr_q && !cfg_q[3]) ? (8'b1 << cfg_q[2:0]) : 8'b0;
  end

endmodule

// File: tb/tb_adc_sched.sv
// tb_adc_sched: directed + randomized checks of adc_sched against a
// cycle-level reference of the scheduling rules and an in-bench ADC model.
module tb_adc_sched;

  localparam int TS = 16;
  localparam int TD = 3;
  localparam int TT = 100;
`ifdef ADC_SCHED_AVG_EN
  localparam int NS = 4;
`else
  localparam int NS = 1;
`endif

  logic        temp_clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [3:0]  cfg [4];
  logic [15:0] req_cfg;
  logic [3:0]  grant, done;
  logic [9:0]  result;
  logic        err, adc_pwdb, adc_rst, adc_temp;
  logic [7:0]  adc_ainsel;
  logic        adc_eoc;
  logic [9:0]  adc_xd;

  int          npass = 0;
  int          ntot  = 0;
  int          ptr   = 0;
  logic [9:0]  exp_res = '0;

  assign req_cfg = {cfg[3], cfg[2], cfg[1], cfg[0]};

  always #5 temp_clk = ~temp_clk;

  adc_sched #(.SETTLE(TS), .DISCARD(TD), .TIMEOUT(TT)) dut (
    .temp_clk  (temp_clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_cfg   (req_cfg),
    .grant     (grant),
    .done      (done),
    .result    (result),
    .err       (err),
    .adc_pwdb  (adc_pwdb),
    .adc_rst   (adc_rst),
    .adc_temp  (adc_temp),
    .adc_ainsel(adc_ainsel),
    .adc_eoc   (adc_eoc),
    .adc_xd    (adc_xd)
  );

  task automatic step();
    @(negedge temp_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int winner(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++)
      if (m[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [7:0] ains(input logic [3:0] c);
    logic [7:0] one;
    one = 8'h01;
    return c[3] ? 8'h00 : (one << c[2:0]);
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_pwdb"}, adc_pwdb, 0);
    chk({tag, "_rst"}, adc_rst, 1);
    chk({tag, "_temp"}, adc_temp, 0);
    chk({tag, "_ainsel"}, adc_ainsel, 0);
  endtask

  // One conversion, entered from the negedge where req was raised (idle)
  // or where the previous done was seen (chained).
  task automatic conv(input logic [3:0] g, input logic [3:0] c,
                      input bit skip, input bit tmo, input bit drop,
                      input int fixb);
    logic [7:0] ai;
    int sum, v, nedge;
    ai = ains(c);
    step();
    chk("done_arb", done, 0);
    if (skip) chk("ainsel_arb", adc_ainsel, ai);
    step();
    chk("grant", grant, g);
    chk("pwdb", adc_pwdb, 1);
    chk("temp", adc_temp, c[3]);
    chk("ainsel", adc_ainsel, ai);
    if (drop) req = 4'b0;
    if (!skip) begin
      chk("rst_first", adc_rst, 1);
      for (int i = 0; i < TS; i++) begin
        step();
        chk("done_settle", done, 0);
        if (i == 0) chk("rst_rel", adc_rst, 0);
      end
    end else begin
      chk("rst_skip", adc_rst, 0);
    end
    if (tmo) begin
      for (int i = 1; i < TT; i++) begin
        step();
        chk("done_tmo_wait", done, 0);
      end
      step();
      exp_res = 10'h3FF;
      chk("done_tmo", done, g);
      chk("err_tmo", err, 1);
      chk("result_tmo", result, exp_res);
    end else begin
      sum = 0;
      nedge = TD + NS;
      for (int e = 0; e < nedge; e++) begin
        repeat ($urandom_range(2, 6)) begin
          step();
          chk("done_conv", done, 0);
        end
        if (e >= TD && fixb >= 0) v = fixb + e - TD;
        else v = int'($urandom_range(1023, 0));
        if (e >= TD) sum += v;
        adc_xd  = 10'(v);
        adc_eoc = 1'b1;
        step();
        if (e < nedge - 1) begin
          chk("done_edge", done, 0);
          adc_eoc = 1'b0;
        end
      end
      exp_res = 10'(sum / NS);
      chk("done", done, g);
      chk("err", err, 0);
      chk("result", result, exp_res);
      chk("temp_done", adc_temp, c[3]);
      chk("ainsel_done", adc_ainsel, ai);
      adc_eoc = 1'b0;
    end
    chk("grant_done", grant, g);
  endtask

  task automatic idle_chk();
    step();
    chk("idle_grant", grant, 0);
    chk("idle_done", done, 0);
    chk("idle_pwdb", adc_pwdb, 0);
    chk("idle_rst", adc_rst, 1);
    chk("idle_temp", adc_temp, 0);
    chk("idle_ainsel", adc_ainsel, 0);
    chk("idle_result", result, exp_res);
  endtask

  task automatic serve(input logic [3:0] m, input bit tmo, input int fixb);
    int w;
    req = m;
    w = winner(m, ptr);
    ptr = (w + 1) % 4;
    conv(4'b0001 << w, cfg[w], 1'b0, tmo, 1'b1, fixb);
    idle_chk();
  endtask

  initial begin
    int w, base;
    bit chained;
    logic [3:0] lastc;
    reset_n = 1'b0;
    req     = '0;
    adc_eoc = 1'b0;
    adc_xd  = '0;
    for (int i = 0; i < 4; i++) cfg[i] = '0;
    repeat (3) step();
    chk_reset_vals("rst_hold");
    reset_n = 1'b1;
    step();
    chk_reset_vals("rst_rel");

    // round robin with all four requesting and distinct cfgs
    base = int'($urandom_range(7, 0));
    for (int i = 0; i < 4; i++)
      cfg[i] = {1'($urandom_range(1, 0)), 3'(base + i)};
    req = 4'hF;
    chained = 1'b0;
    lastc = '0;
    for (int n = 0; n < 5; n++) begin
      w = winner(req, ptr);
      ptr = (w + 1) % 4;
      conv(4'b0001 << w, cfg[w], chained && cfg[w] == lastc,
           1'b0, n == 4, -1);
      lastc = cfg[w];
      chained = 1'b1;
    end
    idle_chk();

    // temp-mode single conversion with a known capture value
    cfg[0] = 4'b1000;
    serve(4'b0001, 1'b0, 10'h155);

    // same cfg repeated by requester 2: second pass skips settling
    cfg[2] = 4'b0101;
    req = 4'b0100;
    w = winner(req, ptr);
    ptr = (w + 1) % 4;
    conv(4'b0100, cfg[2], 1'b0, 1'b0, 1'b0, -1);
    w = winner(req, ptr);
    ptr = (w + 1) % 4;
    conv(4'b0100, cfg[2], 1'b1, 1'b0, 1'b1, -1);
    idle_chk();

    // EOC never rises: timeout path
    cfg[1] = 4'($urandom_range(15, 0));
    serve(4'b0010, 1'b1, -1);

`ifdef ADC_SCHED_AVG_EN
    cfg[3] = 4'b0011;
    serve(4'b1000, 1'b0, 100);
`endif

    // random request masks and configurations
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++) cfg[i] = 4'($urandom_range(15, 0));
      serve(4'($urandom_range(15, 1)), 1'b0, -1);
    end

    // reset pulse in the middle of a conversion
    cfg[0] = 4'($urandom_range(15, 0));
    req = 4'b0001;
    step();
    step();
    req = 4'b0;
    repeat (TS + 3) step();
    adc_eoc = 1'b1;
    adc_xd  = 10'h2AA;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    ptr = 0;
    exp_res = '0;
    step();
    adc_eoc = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (5) begin
      step();
      chk("done_after_rst", done, 0);
    end
    for (int i = 0; i < 4; i++) cfg[i] = 4'($urandom_range(15, 0));
    serve(4'b0110, 1'b0, -1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
